// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types and constants for the instruction fetch unit
// Contents:
//   INSTR_WIDTH      instruction word width
//   RESET_PC_DEFAULT default first fetch address after reset
//   fetch_state_t    fetch FSM state encoding
//   next_pc()        sequential address increment, wraps modulo 2^32
package arm_fetch_pkg;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] next_pc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
// Signals:
//   imem_req    fetch -> memory  request strobe
//   imem_addr   fetch -> memory  request address
//   imem_ready  memory -> fetch  request accepted this cycle
//   imem_rvalid memory -> fetch  read data valid
//   imem_rdata  memory -> fetch  instruction word
interface fetch_unit_if import arm_fetch_pkg::*;;

  logic                   imem_req;
  logic [31:0]            imem_addr;
  logic                   imem_ready;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_buffer.sv
// rtl/fetch_unit_buffer.sv - fetch_buffer: output register plus one-entry skid register
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_flush           drop both entries (redirect)
//   i_load            load i_addr/i_data straight into the output register
//   i_skid_load       park i_addr/i_data in the skid register
//   i_skid_pop        move the skid entry into the output register
//   i_consume         downstream accepts the output register this cycle
//   i_addr, i_data    fetched address and instruction word
//   o_valid, o_pc, o_instruction  output register contents (o_pc = address + 4)
module fetch_buffer import arm_fetch_pkg::*; (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_load,
  input  logic                   i_skid_load,
  input  logic                   i_skid_pop,
  input  logic                   i_consume,
  input  logic [31:0]            i_addr,
  input  logic [INSTR_WIDTH-1:0] i_data,
  output logic                   o_valid,
  output logic [31:0]            o_pc,
  output logic [INSTR_WIDTH-1:0] o_instruction
);

  logic                   r_valid;
  logic [31:0]            r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_skid_valid;
  logic [31:0]            r_skid_pc;
  logic [INSTR_WIDTH-1:0] r_skid_instr;

  // Both entries store the already-incremented pc so the pop path is a plain copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else if (i_flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_pc    <= next_pc(i_addr);
        r_instr <= i_data;
      end else if (i_skid_pop && r_skid_valid) begin
        r_valid      <= 1'b1;
        r_pc         <= r_skid_pc;
        r_instr      <= r_skid_instr;
        r_skid_valid <= 1'b0;
      end else if (r_valid && i_consume) begin
        r_valid <= 1'b0;
      end
      if (i_skid_load) begin
        r_skid_valid <= 1'b1;
        r_skid_pc    <= next_pc(i_addr);
        r_skid_instr <= i_data;
      end
    end
  end

  assign o_valid       = r_valid;
  assign o_pc          = r_pc;
  assign o_instruction = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding-request instruction fetch unit
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   branch_taken    one-cycle redirect pulse
//   branch_address  redirect target (low two bits ignored)
//   freeze          downstream stall
//   imem            instruction memory bus (master side)
//   pc              buffered instruction address + 4
//   instruction     buffered instruction word
//   valid           pc/instruction hold an unconsumed fetch
module fetch_unit import arm_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_address,
  input  logic                   freeze,
  fetch_unit_if.master           imem,
  output logic [31:0]            pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   valid
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic         r_discard;

  logic [31:0]  w_target;
  logic         w_resp;
  logic         w_keep;
  logic         w_load;
  logic         w_skid_load;
  logic         w_skid_pop;
  logic         w_outstanding;

  assign w_target = branch_address & 32'hFFFF_FFFC;

  // A response only counts in WAIT; a stale word after a redirect is dropped.
  assign w_resp      = (r_state == WAIT) && imem.imem_rvalid;
  assign w_keep      = w_resp && !r_discard && !branch_taken;
  assign w_load      = w_keep && (!valid || !freeze);
  assign w_skid_load = w_keep && valid && freeze;
  assign w_skid_pop  = (r_state == HOLD) && !freeze && !branch_taken;

  // A redirect while a request is in flight (and its word not arriving now)
  // must still swallow that word before a new request may be issued.
  assign w_outstanding = ((r_state == WAIT) && !imem.imem_rvalid) ||
                         ((r_state == REQ)  && imem.imem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
    end else if (branch_taken) begin
      r_fetch_pc <= w_target;
      if (w_outstanding) begin
        r_discard <= 1'b1;
        r_state   <= WAIT;
      end else begin
        r_discard <= 1'b0;
        r_state   <= REQ;
      end
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (imem.imem_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= REQ;
            end else if (w_skid_load) begin
              r_state <= HOLD;
            end else begin
              r_fetch_pc <= next_pc(r_fetch_pc);
              r_state    <= REQ;
            end
          end
        end
        HOLD: begin
          if (!freeze) begin
            r_fetch_pc <= next_pc(r_fetch_pc);
            r_state    <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = (r_state == REQ);
  assign imem.imem_addr = r_fetch_pc;

  fetch_buffer u_buffer (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (branch_taken),
    .i_load        (w_load),
    .i_skid_load   (w_skid_load),
    .i_skid_pop    (w_skid_pop),
    .i_consume     (!freeze),
    .i_addr        (r_fetch_pc),
    .i_data        (imem.imem_rdata),
    .o_valid       (valid),
    .o_pc          (pc),
    .o_instruction (instruction)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        freeze;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .freeze         (freeze),
    .imem           (imem_bus),
    .pc             (pc),
    .instruction    (instruction),
    .valid          (valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one accepted request, then return data on the following cycle.
  task automatic fetch(input logic [31:0] data);
    imem_bus.imem_ready = 1'b1;
    step();
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = data;
    step();
    imem_bus.imem_rvalid = 1'b0;
  endtask

  initial begin
    rst                  = 1'b0;
    branch_taken         = 1'b0;
    branch_address       = '0;
    freeze               = 1'b0;
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;

    step();
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_pc", pc, 32'd0);
    chk("reset_instr", instruction, 32'd0);
    chk("reset_req", {31'd0, imem_bus.imem_req}, 32'd0);

    rst = 1'b1;
    step();
    chk("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("first_addr", imem_bus.imem_addr, 32'h0000_0000);

    imem_bus.imem_ready = 1'b1;
    step();
    chk("wait_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hE3A0_0001;
    step();
    imem_bus.imem_rvalid = 1'b0;
    chk("f0_valid", {31'd0, valid}, 32'd1);
    chk("f0_pc", pc, 32'd4);
    chk("f0_instr", instruction, 32'hE3A0_0001);
    chk("f1_addr", imem_bus.imem_addr, 32'd4);

    fetch(32'h0000_000A);
    chk("f1_pc", pc, 32'd8);
    chk("f1_instr", instruction, 32'h0000_000A);
    chk("f2_addr", imem_bus.imem_addr, 32'd8);

    fetch(32'h0000_000B);
    chk("f2_pc", pc, 32'd12);
    chk("f2_instr", instruction, 32'h0000_000B);
    chk("f2_valid", {31'd0, valid}, 32'd1);
    chk("f3_addr", imem_bus.imem_addr, 32'd12);

    // Second word returns under freeze: parked in skid, first word held.
    freeze = 1'b1;
    fetch(32'h1111_1111);
    chk("hold_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("hold_pc", pc, 32'd12);
    chk("hold_instr", instruction, 32'h0000_000B);
    chk("hold_valid", {31'd0, valid}, 32'd1);
    step();
    chk("hold2_instr", instruction, 32'h0000_000B);
    chk("hold2_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    freeze = 1'b0;
    step();
    chk("pop_pc", pc, 32'd16);
    chk("pop_instr", instruction, 32'h1111_1111);
    chk("pop_valid", {31'd0, valid}, 32'd1);
    chk("pop_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("pop_next_addr", imem_bus.imem_addr, 32'd16);
    step();
    chk("consume_valid", {31'd0, valid}, 32'd0);

    // Redirect while a request is outstanding: returned word is dropped.
    imem_bus.imem_ready = 1'b1;
    step();
    imem_bus.imem_ready = 1'b0;
    branch_taken        = 1'b1;
    branch_address      = 32'h0000_0103;
    step();
    branch_taken = 1'b0;
    chk("br_wait_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_bus.imem_rvalid = 1'b0;
    chk("br_drop_valid", {31'd0, valid}, 32'd0);
    chk("br_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("br_addr", imem_bus.imem_addr, 32'h0000_0100);
    fetch(32'h0000_0022);
    chk("br_pc", pc, 32'h0000_0104);
    chk("br_instr", instruction, 32'h0000_0022);
    chk("br_next_addr", imem_bus.imem_addr, 32'h0000_0104);

    // Redirect coinciding with the response: word dropped, straight to REQ.
    imem_bus.imem_ready = 1'b1;
    step();
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h0000_0033;
    branch_taken         = 1'b1;
    branch_address       = 32'h0000_0200;
    step();
    imem_bus.imem_rvalid = 1'b0;
    branch_taken         = 1'b0;
    chk("brv_valid", {31'd0, valid}, 32'd0);
    chk("brv_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("brv_addr", imem_bus.imem_addr, 32'h0000_0200);

    // Address wrap at the top of memory.
    branch_taken   = 1'b1;
    branch_address = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    chk("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0044);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_instr", instruction, 32'h0000_0044);
    chk("wrap_valid", {31'd0, valid}, 32'd1);
    chk("wrap_next_addr", imem_bus.imem_addr, 32'h0000_0000);

    // Reset during WAIT, then a late response that must be ignored.
    freeze              = 1'b1;
    imem_bus.imem_ready = 1'b1;
    step();
    imem_bus.imem_ready = 1'b0;
    chk("rw_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rw_instr", instruction, 32'h0000_0044);
    rst = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, valid}, 32'd0);
    chk("rst_async_pc", pc, 32'd0);
    chk("rst_async_instr", instruction, 32'd0);
    chk("rst_async_req", {31'd0, imem_bus.imem_req}, 32'd0);
    step();
    rst                  = 1'b1;
    freeze               = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h0000_0055;
    step();
    chk("post_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("post_rst_addr", imem_bus.imem_addr, 32'h0000_0000);
    chk("post_rst_valid", {31'd0, valid}, 32'd0);
    step();
    imem_bus.imem_rvalid = 1'b0;
    chk("late_rvalid_ignored", {31'd0, valid}, 32'd0);
    chk("late_rvalid_req", {31'd0, imem_bus.imem_req}, 32'd1);
    fetch(32'h0000_0066);
    chk("post_rst_pc", pc, 32'd4);
    chk("post_rst_instr", instruction, 32'h0000_0066);
    chk("post_rst_fvalid", {31'd0, valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
